// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path.
// ILLEGAL_TRAP_EN adds the TRAP state for illegal opcode/func3.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        ALUWB,
        BRANCH,
        JAL,
        JALR,
        LUI
`ifdef ILLEGAL_TRAP_EN
        , TRAP
`endif
    } state_t;

    typedef enum logic [1:0] {
        AOP_ADD,
        AOP_R,
        AOP_I,
        AOP_BR
    } alu_op_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_IMM    = 2'b10;
    localparam logic [1:0] RES_ALU    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // True when the opcode is supported and its func3 names a known op
    function automatic logic op_legal(
        input logic [6:0] op,
        input logic [2:0] f3
    );
        case (op)
            OP_R:      return f3 inside {3'b000, 3'b111, 3'b110, 3'b010};
            OP_I:      return f3 inside {3'b000, 3'b100, 3'b110, 3'b010};
            OP_LOAD:   return f3 == 3'b010;
            OP_STORE:  return f3 == 3'b010;
            OP_BRANCH: return f3 inside {3'b000, 3'b001, 3'b100, 3'b101};
            OP_JALR:   return f3 == 3'b000;
            OP_JAL:    return 1'b1;
            OP_LUI:    return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the ALU operation class plus func3/func7 to an alu_control code.
// Unrecognised R/I combinations fall back to add.
module alu_decoder
    import riscv_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 3
) (
    input  alu_op_t               alu_op,
    input  logic [2:0]            func3,
    input  logic [6:0]            func7,
    output logic [ALU_CTRL_W-1:0] alu_control
);

    logic [2:0] code;

    always_comb begin
        code = ALU_ADD;
        unique case (alu_op)
            AOP_R: begin
                case ({func3, func7})
                    {3'b000, 7'b0000000}: code = ALU_ADD;
                    {3'b000, 7'b0100000}: code = ALU_SUB;
                    {3'b111, 7'b0000000}: code = ALU_AND;
                    {3'b110, 7'b0000000}: code = ALU_OR;
                    {3'b010, 7'b0000000}: code = ALU_SLT;
                    default:              code = ALU_ADD;
                endcase
            end
            AOP_I: begin
                case (func3)
                    3'b000:  code = ALU_ADD;
                    3'b100:  code = ALU_XOR;
                    3'b110:  code = ALU_OR;
                    3'b010:  code = ALU_SLT;
                    default: code = ALU_ADD;
                endcase
            end
            AOP_BR:  code = func3[2] ? ALU_SLT : ALU_SUB;
            default: code = ALU_ADD;
        endcase
    end

    assign alu_control = ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control FSM for the RV32I subset.
// Define ILLEGAL_TRAP_EN to trap on illegal opcode/func3 instead of NOP.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 3,
    parameter int IMM_SRC_W  = 3,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            opcode,
    input  logic [2:0]            func3,
    input  logic [6:0]            func7,
    input  logic                  zero,
    input  logic                  neg,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  adr_src,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [IMM_SRC_W-1:0]  imm_src,
    output logic [1:0]            result_src,
    output logic                  reg_write,
    output logic                  instr_done,
    output logic                  mem_timeout
);

    localparam int CW = $clog2(MAX_WAIT + 2);
    localparam logic [CW-1:0] WMAX = CW'(MAX_WAIT);

    state_t        state;
    state_t        state_next;
    alu_op_t       alu_op;
    logic [2:0]    imm_code;
    logic          taken;
    logic          waiting;
    logic [CW-1:0] wait_cnt;
    logic          timeout_q;

    alu_decoder #(
        .ALU_CTRL_W(ALU_CTRL_W)
    ) u_alu_dec (
        .alu_op     (alu_op),
        .func3      (func3),
        .func7      (func7),
        .alu_control(alu_control)
    );

    assign imm_src     = IMM_SRC_W'(imm_code);
    assign waiting     = state inside {FETCH, MEMRD, MEMWR};
    assign mem_timeout = timeout_q & ~rst;

    always_comb begin
        taken = 1'b0;
        case (func3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = neg;
            3'b101:  taken = ~neg;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = AOP_ADD;
        imm_code   = IMM_I;
        result_src = RES_ALUOUT;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        // Reset forces every control output low in the same cycle
        if (!rst) begin
            unique case (state)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        state_next = DECODE;
                    end
                end
                DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    imm_code  = IMM_B;
                    if (!op_legal(opcode, func3)) begin
`ifdef ILLEGAL_TRAP_EN
                        state_next = TRAP;
`else
                        instr_done = 1'b1;
                        state_next = FETCH;
`endif
                    end else begin
                        case (opcode)
                            OP_R:      state_next = EXEC_R;
                            OP_I:      state_next = EXEC_I;
                            OP_LOAD:   state_next = MEMADR;
                            OP_STORE:  state_next = MEMADR;
                            OP_BRANCH: state_next = BRANCH;
                            OP_JAL:    state_next = JAL;
                            OP_JALR:   state_next = JALR;
                            OP_LUI:    state_next = LUI;
                            default:   state_next = FETCH;
                        endcase
                    end
                end
                EXEC_R: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_RS2;
                    alu_op     = AOP_R;
                    state_next = ALUWB;
                end
                EXEC_I: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_IMM;
                    alu_op     = AOP_I;
                    state_next = ALUWB;
                end
                ALUWB: begin
                    reg_write  = 1'b1;
                    result_src = RES_ALUOUT;
                    instr_done = 1'b1;
                    state_next = FETCH;
                end
                MEMADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    if (opcode == OP_STORE) begin
                        imm_code   = IMM_S;
                        state_next = MEMWR;
                    end else begin
                        state_next = MEMRD;
                    end
                end
                MEMRD: begin
                    adr_src  = 1'b1;
                    mem_read = 1'b1;
                    if (mem_ready) state_next = MEMWB;
                end
                MEMWB: begin
                    reg_write  = 1'b1;
                    result_src = RES_MEM;
                    instr_done = 1'b1;
                    state_next = FETCH;
                end
                MEMWR: begin
                    adr_src   = 1'b1;
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        state_next = FETCH;
                    end
                end
                BRANCH: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_RS2;
                    alu_op     = AOP_BR;
                    pc_write   = taken;
                    result_src = RES_ALUOUT;
                    instr_done = 1'b1;
                    state_next = FETCH;
                end
                JAL, JALR: begin
                    // rd gets old PC + 4; PC takes the target held in ALU-out
                    alu_src_a  = SRCA_OLDPC;
                    alu_src_b  = SRCB_FOUR;
                    imm_code   = (state == JAL) ? IMM_J : IMM_I;
                    pc_write   = 1'b1;
                    reg_write  = 1'b1;
                    result_src = RES_ALU;
                    instr_done = 1'b1;
                    state_next = FETCH;
                end
                LUI: begin
                    imm_code   = IMM_U;
                    reg_write  = 1'b1;
                    result_src = RES_IMM;
                    instr_done = 1'b1;
                    state_next = FETCH;
                end
`ifdef ILLEGAL_TRAP_EN
                TRAP: state_next = TRAP;
`endif
                default: state_next = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_next;
            if (waiting && !mem_ready) begin
                if (wait_cnt != WMAX) wait_cnt <= wait_cnt + CW'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (MAX_WAIT != 0 && waiting && !mem_ready && wait_cnt == WMAX)
                timeout_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (instance built with MAX_WAIT=3).
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       zero;
    logic       neg;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [2:0] imm_src;
    logic [1:0] result_src;
    logic       reg_write;
    logic       instr_done;
    logic       mem_timeout;
    logic [19:0] all_out;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    multicycle_controller #(
        .ALU_CTRL_W(3),
        .IMM_SRC_W (3),
        .MAX_WAIT  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .func3      (func3),
        .func7      (func7),
        .zero       (zero),
        .neg        (neg),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_control(alu_control),
        .imm_src    (imm_src),
        .result_src (result_src),
        .reg_write  (reg_write),
        .instr_done (instr_done),
        .mem_timeout(mem_timeout)
    );

    assign all_out = {pc_write, adr_src, mem_read, mem_write, ir_write,
                      alu_src_a, alu_src_b, alu_control, imm_src,
                      result_src, reg_write, instr_done, mem_timeout};

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7);
        opcode = op;
        func3  = f3;
        func7  = f7;
        mem_ready = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        opcode = 7'b0110011;
        nxt();
        total++;
        if (all_out !== 20'h0) begin
            bad++;
            $display("FAIL rst_outs got=%b exp=0", all_out);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({mem_read, adr_src, ir_write, pc_write, alu_src_b, mem_timeout}
            !== 7'b1011_10_0) begin
            bad++;
            $display("FAIL rst_fetch got=%b exp=1011100",
                     {mem_read, adr_src, ir_write, pc_write, alu_src_b, mem_timeout});
        end
    endtask

    task automatic test_add();
        set_instr(7'b0110011, 3'b000, 7'b0000000);
        total++;
        if ({ir_write, pc_write, reg_write, instr_done} !== 4'b1100) begin
            bad++;
            $display("FAIL add_c1 got=%b exp=1100",
                     {ir_write, pc_write, reg_write, instr_done});
        end
        nxt();
        total++;
        if ({alu_src_a, alu_src_b, imm_src, reg_write, instr_done}
            !== {2'b01, 2'b01, 3'b010, 2'b00}) begin
            bad++;
            $display("FAIL add_c2 got=%b exp=010101000",
                     {alu_src_a, alu_src_b, imm_src, reg_write, instr_done});
        end
        nxt();
        total++;
        if ({alu_src_a, alu_src_b, alu_control, reg_write, instr_done}
            !== {2'b10, 2'b00, 3'b000, 2'b00}) begin
            bad++;
            $display("FAIL add_c3 got=%b exp=100000000",
                     {alu_src_a, alu_src_b, alu_control, reg_write, instr_done});
        end
        nxt();
        total++;
        if ({reg_write, result_src, instr_done} !== 4'b1001) begin
            bad++;
            $display("FAIL add_c4 got=%b exp=1001",
                     {reg_write, result_src, instr_done});
        end
        nxt();
        total++;
        if ({mem_read, reg_write, instr_done} !== 3'b100) begin
            bad++;
            $display("FAIL add_refetch got=%b exp=100",
                     {mem_read, reg_write, instr_done});
        end
    endtask

    task automatic test_alu_ops();
        logic [6:0] ops[6]  = '{7'b0110011, 7'b0010011, 7'b0110011,
                                7'b0110011, 7'b0010011, 7'b0110011};
        logic [2:0] f3s[6]  = '{3'b000, 3'b100, 3'b111, 3'b010, 3'b110, 3'b000};
        logic [6:0] f7s[6]  = '{7'b0100000, 7'b0000000, 7'b0000000,
                                7'b0000000, 7'b0000000, 7'b0000001};
        logic [2:0] exps[6] = '{3'b001, 3'b101, 3'b010, 3'b100, 3'b011, 3'b000};
        logic [1:0] expb;
        for (int i = 0; i < 6; i++) begin
            set_instr(ops[i], f3s[i], f7s[i]);
            nxt();
            nxt();
            expb = (ops[i] == 7'b0010011) ? 2'b01 : 2'b00;
            total++;
            if ({alu_control, alu_src_b} !== {exps[i], expb}) begin
                bad++;
                $display("FAIL alu_op%0d got=%b exp=%b", i,
                         {alu_control, alu_src_b}, {exps[i], expb});
            end
            nxt();
            total++;
            if ({reg_write, instr_done} !== 2'b11) begin
                bad++;
                $display("FAIL alu_wb%0d got=%b exp=11", i, {reg_write, instr_done});
            end
            nxt();
        end
    endtask

    task automatic test_load_wait();
        set_instr(7'b0000011, 3'b010, 7'b0000000);
        nxt();
        nxt();
        total++;
        if ({alu_src_a, alu_src_b, imm_src, alu_control}
            !== {2'b10, 2'b01, 3'b000, 3'b000}) begin
            bad++;
            $display("FAIL lw_adr got=%b exp=1001000000",
                     {alu_src_a, alu_src_b, imm_src, alu_control});
        end
        for (int i = 0; i < 3; i++) begin
            nxt();
            mem_ready = (i == 2);
            #1;
            total++;
            if ({mem_read, adr_src, reg_write, instr_done} !== 4'b1100) begin
                bad++;
                $display("FAIL lw_rd%0d got=%b exp=1100", i,
                         {mem_read, adr_src, reg_write, instr_done});
            end
        end
        nxt();
        total++;
        if ({reg_write, result_src, instr_done, mem_timeout} !== 5'b10110) begin
            bad++;
            $display("FAIL lw_wb got=%b exp=10110",
                     {reg_write, result_src, instr_done, mem_timeout});
        end
        mem_ready = 1'b1;
        nxt();
    endtask

    task automatic test_store();
        set_instr(7'b0100011, 3'b010, 7'b0000000);
        nxt();
        nxt();
        total++;
        if (imm_src !== 3'b001) begin
            bad++;
            $display("FAIL sw_imm got=%b exp=001", imm_src);
        end
        nxt();
        total++;
        if ({mem_write, adr_src, mem_read, reg_write, instr_done} !== 5'b11001) begin
            bad++;
            $display("FAIL sw_wr got=%b exp=11001",
                     {mem_write, adr_src, mem_read, reg_write, instr_done});
        end
        nxt();
    endtask

    task automatic test_branch();
        logic [2:0] f3s[6] = '{3'b000, 3'b000, 3'b101, 3'b100, 3'b001, 3'b100};
        logic       zs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       ns[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       tk[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [2:0] ac[6]  = '{3'b001, 3'b001, 3'b100, 3'b100, 3'b001, 3'b100};
        for (int i = 0; i < 6; i++) begin
            set_instr(7'b1100011, f3s[i], 7'b0000000);
            zero = zs[i];
            neg  = ns[i];
            nxt();
            nxt();
            total++;
            if ({pc_write, instr_done, result_src, alu_control, reg_write}
                !== {tk[i], 1'b1, 2'b00, ac[i], 1'b0}) begin
                bad++;
                $display("FAIL br%0d got=%b exp=%b", i,
                         {pc_write, instr_done, result_src, alu_control, reg_write},
                         {tk[i], 1'b1, 2'b00, ac[i], 1'b0});
            end
            nxt();
        end
        zero = 1'b0;
        neg  = 1'b0;
    endtask

    task automatic test_jumps_lui();
        set_instr(7'b1101111, 3'b000, 7'b0000000);
        nxt();
        nxt();
        total++;
        if ({pc_write, reg_write, imm_src, result_src, instr_done}
            !== {2'b11, 3'b100, 2'b11, 1'b1}) begin
            bad++;
            $display("FAIL jal got=%b exp=11100111",
                     {pc_write, reg_write, imm_src, result_src, instr_done});
        end
        nxt();
        set_instr(7'b1100111, 3'b000, 7'b0000000);
        nxt();
        nxt();
        total++;
        if ({pc_write, reg_write, imm_src, result_src, instr_done}
            !== {2'b11, 3'b000, 2'b11, 1'b1}) begin
            bad++;
            $display("FAIL jalr got=%b exp=11000111",
                     {pc_write, reg_write, imm_src, result_src, instr_done});
        end
        nxt();
        set_instr(7'b0110111, 3'b000, 7'b0000000);
        nxt();
        nxt();
        total++;
        if ({pc_write, reg_write, result_src, imm_src, instr_done}
            !== {2'b01, 2'b10, 3'b011, 1'b1}) begin
            bad++;
            $display("FAIL lui got=%b exp=01100111",
                     {pc_write, reg_write, result_src, imm_src, instr_done});
        end
        nxt();
    endtask

`ifdef ILLEGAL_TRAP_EN
    task automatic test_illegal();
        set_instr(7'b0000000, 3'b000, 7'b0000000);
        nxt();
        total++;
        if (instr_done !== 1'b0) begin
            bad++;
            $display("FAIL trap_dec got=%b exp=0", instr_done);
        end
        for (int i = 0; i < 3; i++) begin
            nxt();
            total++;
            if (all_out !== 20'h0) begin
                bad++;
                $display("FAIL trap_hold%0d got=%b exp=0", i, all_out);
            end
        end
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        #1;
        total++;
        if (mem_read !== 1'b1) begin
            bad++;
            $display("FAIL trap_exit got=%b exp=1", mem_read);
        end
    endtask
`else
    task automatic test_illegal();
        logic [6:0] ops[2] = '{7'b0000000, 7'b0110011};
        logic [2:0] f3s[2] = '{3'b000, 3'b001};
        for (int i = 0; i < 2; i++) begin
            set_instr(ops[i], f3s[i], 7'b0000000);
            nxt();
            total++;
            if ({instr_done, reg_write, pc_write, mem_write} !== 4'b1000) begin
                bad++;
                $display("FAIL nop%0d_dec got=%b exp=1000", i,
                         {instr_done, reg_write, pc_write, mem_write});
            end
            nxt();
            total++;
            if ({mem_read, instr_done} !== 2'b10) begin
                bad++;
                $display("FAIL nop%0d_fetch got=%b exp=10", i, {mem_read, instr_done});
            end
        end
    endtask
`endif

    task automatic test_reset_memwr();
        set_instr(7'b0100011, 3'b010, 7'b0000000);
        nxt();
        nxt();
        nxt();
        mem_ready = 1'b0;
        #1;
        total++;
        if ({mem_write, instr_done} !== 2'b10) begin
            bad++;
            $display("FAIL rstwr_wait got=%b exp=10", {mem_write, instr_done});
        end
        rst = 1'b1;
        #1;
        total++;
        if (all_out !== 20'h0) begin
            bad++;
            $display("FAIL rstwr_rst got=%b exp=0", all_out);
        end
        nxt();
        rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        total++;
        if ({mem_read, mem_write, instr_done} !== 3'b100) begin
            bad++;
            $display("FAIL rstwr_fetch got=%b exp=100",
                     {mem_read, mem_write, instr_done});
        end
    endtask

    task automatic test_timeout();
        set_instr(7'b0100011, 3'b010, 7'b0000000);
        nxt();
        nxt();
        for (int i = 0; i < 4; i++) begin
            nxt();
            mem_ready = 1'b0;
            #1;
            total++;
            if ({mem_write, instr_done, mem_timeout} !== 3'b100) begin
                bad++;
                $display("FAIL to_wait%0d got=%b exp=100", i,
                         {mem_write, instr_done, mem_timeout});
            end
        end
        nxt();
        mem_ready = 1'b1;
        #1;
        total++;
        if ({mem_write, instr_done, mem_timeout} !== 3'b111) begin
            bad++;
            $display("FAIL to_set got=%b exp=111",
                     {mem_write, instr_done, mem_timeout});
        end
        nxt();
        nxt();
        total++;
        if (mem_timeout !== 1'b1) begin
            bad++;
            $display("FAIL to_sticky got=%b exp=1", mem_timeout);
        end
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        #1;
        total++;
        if (mem_timeout !== 1'b0) begin
            bad++;
            $display("FAIL to_clear got=%b exp=0", mem_timeout);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        opcode = '0;
        func3 = '0;
        func7 = '0;
        zero = 1'b0;
        neg = 1'b0;
        mem_ready = 1'b0;
        test_reset();
        test_add();
        test_alu_ops();
        test_load_wait();
        test_store();
        test_branch();
        test_jumps_lui();
        test_illegal();
        test_reset_memwr();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
